// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer.
// Holds the sequencer state encoding, the funct3 op codes and the datapath
// width / iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int XLEN = 32;
  localparam int ITER = 32;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational result correction for the multiply/divide sequencer.
// Takes the unsigned magnitude result and applies the latched signs, selects
// the high/low product word or quotient/remainder, and substitutes the
// divide-by-zero and signed-overflow results.
// Ports:
//   funct3  - latched op select
//   mag     - magnitude result: product[63:0], or {remainder, quotient}
//   a_orig  - original rs1 value (remainder on divide by zero)
//   neg     - negate product / quotient
//   rem_neg - negate remainder
//   div0    - divisor was zero
//   ovf     - signed overflow (0x80000000 / -1)
//   result  - corrected 32-bit result
// Macro MULDIV_DIVIDE_EN: when undefined, divide ops yield 0.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [2*XLEN-1:0] mag,
  input  logic [XLEN-1:0]   a_orig,
  input  logic              neg,
  input  logic              rem_neg,
  input  logic              div0,
  input  logic              ovf,
  output logic [XLEN-1:0]   result
);

  logic signed [2*XLEN-1:0] prod;
`ifdef MULDIV_DIVIDE_EN
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
`endif

  always_comb begin
    result = '0;
    prod   = neg ? -$signed(mag) : $signed(mag);
`ifdef MULDIV_DIVIDE_EN
    quo = neg ? -mag[XLEN-1:0] : mag[XLEN-1:0];
    rem = rem_neg ? -mag[2*XLEN-1:XLEN] : mag[2*XLEN-1:XLEN];
    if (div0) begin
      quo = '1;
      rem = a_orig;
    end else if (ovf) begin
      quo = 32'h8000_0000;
      rem = '0;
    end
`endif
    if (!funct3[2]) begin
      result = (funct3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
`ifdef MULDIV_DIVIDE_EN
    else begin
      result = funct3[1] ? rem : quo;
    end
`endif
  end

`ifdef MULDIV_DIVIDE_EN
`else
  logic unused_div;
  assign unused_div = ^{a_orig, rem_neg, div0, ovf};
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension multiply/divide sequencer.
// One shift-add (multiply) or restoring (divide) step per RUN cycle,
// 32 steps, then a one-cycle DONE where the signed result is presented.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - request, sampled in IDLE only
//   funct3_in       - op select (MUL..REMU)
//   op_a, op_b      - rs1 / rs2 operands
//   rd_in           - destination register of the request
//   kill            - pipeline flush, aborts any op in flight
//   busy            - high in RUN and DONE
//   stall           - (start & IDLE & !kill) | RUN
//   done            - one-cycle pulse, result and rd_out valid
//   result, rd_out  - hold their values until the next done
// Macro MULDIV_DIVIDE_EN: enables the divide datapath. When undefined,
// divide ops go straight from IDLE to DONE with result 0.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        kill,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  state_t state, state_nxt;

  logic [4:0]        count;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q;      // original rs1, remainder on divide by zero
  logic [XLEN-1:0]   m_q;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic              neg_q, rem_neg_q, div0_q, ovf_q;
  logic [XLEN-1:0]   res_q, fixed;
  logic [4:0]        rd_lat, rd_q;

  logic              a_neg, b_neg, div0_in, ovf_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum;
`ifdef MULDIV_DIVIDE_EN
  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   rem_sub;
`endif

  // Request decode: which operands are taken as signed magnitudes.
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (funct3_in)
      F3_MULH, F3_DIV, F3_REM: begin
        a_neg = op_a[31];
        b_neg = op_b[31];
      end
      F3_MULHSU: a_neg = op_a[31];
      default: ;
    endcase
    a_mag   = a_neg ? -op_a : op_a;
    b_mag   = b_neg ? -op_b : op_b;
    div0_in = (op_b == '0);
    ovf_in  = ((funct3_in == F3_DIV) || (funct3_in == F3_REM)) &&
              (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  end

  // One iteration. Multiply: acc = {partial, multiplier}, shift right.
  // Divide: acc = {remainder, dividend/quotient}, shift left.
  always_comb begin
    acc_nxt = acc;
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_q} : '0);
`ifdef MULDIV_DIVIDE_EN
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    rem_sub = shifted[XLEN-1:0] - m_q;
`endif
    if (!f3_q[2]) begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
`ifdef MULDIV_DIVIDE_EN
    else if (shifted >= {1'b0, m_q}) begin
      acc_nxt = {rem_sub, acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !kill) begin
`ifdef MULDIV_DIVIDE_EN
        state_nxt = RUN;
`else
        state_nxt = funct3_in[2] ? DONE : RUN;
`endif
      end
      RUN:  if (kill) state_nxt = IDLE;
            else if (count == 5'(ITER - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      f3_q      <= '0;
      a_q       <= '0;
      m_q       <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      rd_lat    <= '0;
      rd_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start && !kill) begin
          count     <= '0;
          f3_q      <= funct3_in;
          a_q       <= op_a;
          m_q       <= funct3_in[2] ? b_mag : a_mag;
          acc       <= {{XLEN{1'b0}}, (funct3_in[2] ? a_mag : b_mag)};
          neg_q     <= a_neg ^ b_neg;
          rem_neg_q <= a_neg;
          div0_q    <= div0_in;
          ovf_q     <= ovf_in;
          rd_lat    <= rd_in;
        end
        RUN: begin
          acc   <= acc_nxt;
          count <= count + 5'd1;
        end
        DONE: begin
          res_q <= fixed;
          rd_q  <= rd_lat;
        end
        default: ;
      endcase
    end
  end

  muldiv_sign_fix u_sign_fix (
    .funct3  (f3_q),
    .mag     (acc),
    .a_orig  (a_q),
    .neg     (neg_q),
    .rem_neg (rem_neg_q),
    .div0    (div0_q),
    .ovf     (ovf_q),
    .result  (fixed)
  );

  assign busy   = (state == RUN) || (state == DONE);
  assign done   = (state == DONE);
  assign stall  = (start && (state == IDLE) && !kill) || (state == RUN);
  assign result = done ? fixed : res_q;
  assign rd_out = done ? rd_lat : rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, aborts,
// back-to-back requests and randomized ops against an arithmetic model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3_in;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3_in (funct3_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .kill      (kill),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result computed directly from the ISA arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sa, sb, ua, ub, p;
    logic [63:0] pb;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      F3_MUL:    p = ua * ub;
      F3_MULH:   p = sa * sb;
      F3_MULHSU: p = sa * ub;
      F3_MULHU:  p = ua * ub;
      default:   p = 0;
    endcase
    pb = p;
    if (f3 == F3_MUL) return pb[31:0];
    if (!f3[2]) return pb[63:32];
`ifdef MULDIV_DIVIDE_EN
    if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
    case (f3)
      F3_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib);
      F3_REM:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
      F3_DIVU: return a / b;
      default: return a % b;
    endcase
`else
    return 32'h0;
`endif
  endfunction

  // Edges from acceptance to the first cycle where done is visible.
  function automatic int latency(input logic [2:0] f3);
`ifdef MULDIV_DIVIDE_EN
    return 32;
`else
    return f3[2] ? 0 : 32;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int   k;
    logic stall_ok;
    @(negedge clk);
    start = 1'b1; funct3_in = f3; op_a = a; op_b = b; rd_in = rd;
    #1;
    check({tag, "_stall_req"}, 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    stall_ok = 1'b1;
    while (!done && k < 60) begin
      if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(latency(f3)));
    check({tag, "_stall_run"}, 32'(stall_ok), 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, 32'(rd_out), 32'(rd));
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, result, exp);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic abort_op(input string tag, input logic use_rst, input logic [31:0] exp_res);
    int pulses;
    @(negedge clk);
    start = 1'b1; funct3_in = F3_MUL; op_a = 32'd1234; op_b = 32'd5678; rd_in = 5'd17;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    if (use_rst) rst = 1'b1; else kill = 1'b1;
    @(negedge clk);
    rst = 1'b0; kill = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    pulses = 0;
    repeat (40) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check({tag, "_no_done"}, 32'(pulses), 32'd0);
    check({tag, "_result"}, result, exp_res);
  endtask

  initial begin
    logic [31:0] prev, r_a, r_b, exp1;
    logic [2:0]  r_f;
    int          k;

    rst = 1'b1; start = 1'b0; kill = 1'b0;
    funct3_in = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_rd", 32'(rd_out), 32'h0);
    check("reset_stall", 32'(stall), 32'd0);

    run_op("mul_7_m3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    run_op("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
    run_op("mulh_neg", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000);
    run_op("mulhsu_neg", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
`ifdef MULDIV_DIVIDE_EN
    run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
    run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
    run_op("divu_by0", F3_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
    run_op("rem_by0", F3_REM, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFF9);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    run_op("remu_big", F3_REMU, 32'hFFFF_FFFF, 32'd10, 5'd15, 32'd5);
`else
    run_op("div_nodiv", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h0);
    run_op("remu_nodiv", F3_REMU, 32'd100, 32'd7, 5'd10, 32'h0);
`endif

    // kill wins over start in IDLE
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3_in = F3_MUL; op_a = 32'd3; op_b = 32'd3;
    #1;
    check("kill_prio_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_prio_busy", 32'(busy), 32'd0);

    prev = result;
    abort_op("abort_kill", 1'b0, prev);
    abort_op("abort_rst", 1'b1, 32'h0);
    check("abort_rst_rd", 32'(rd_out), 32'h0);

    // back-to-back with start held through busy
    exp1 = model(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    start = 1'b1; funct3_in = F3_MULHU; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; rd_in = 5'd3;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("b2b_latency1", 32'(k), 32'd32);
    check("b2b_result1", result, exp1);
    funct3_in = F3_DIV; op_a = 32'hFFFF_FFF9; op_b = 32'd2; rd_in = 5'd9;
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_stall", 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("b2b_latency2", 32'(k), 32'(latency(F3_DIV)));
    check("b2b_result2", result, model(F3_DIV, 32'hFFFF_FFF9, 32'd2));
    check("b2b_rd2", 32'(rd_out), 32'd9);

    // randomized ops, operands biased toward boundary values
    for (int i = 0; i < 24; i++) begin
      r_f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: r_a = 32'h0;
        1: r_a = 32'h8000_0000;
        2: r_a = 32'hFFFF_FFFF;
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: r_b = 32'h0;
        1: r_b = 32'h1;
        2: r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, r_f), r_f, r_a, r_b, 5'($urandom), model(r_f, r_a, r_b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  execution stage requests an M-extension op; sampled only in IDLE.
REQ-005 funct3_in  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  32  rs1 operand, already forwarded.
REQ-007 op_b  input  32  rs2 operand, already forwarded.
REQ-008 rd_in  input  5  destination register of the request.
REQ-009 kill  input  1  pipeline flush; aborts any op in flight.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 stall  output  1  combinational; (start & IDLE & !kill) | RUN; freezes fetch, decode and execution registers.
REQ-012 done  output  1  one-cycle pulse; result and rd_out valid.
REQ-013 result  output  32  final product or quotient/remainder.
REQ-014 rd_out  output  5  rd_in captured at start.

Function
REQ-015 States SHALL be IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on start & !kill;
- RUN->DONE when iteration count = 31;
- DONE->IDLE unconditionally;
- any state->IDLE on kill.
REQ-016 On the accepting edge N the block SHALL latch operands, funct3_in and rd_in, and clear the 5-bit count to 0.
REQ-017 The block SHALL perform one iteration per RUN cycle, 32 in total; the 32nd occurs at edge N+32, entering DONE.
REQ-018 done SHALL be high exactly during the cycle following edge N+32, and low otherwise.
REQ-019 Multiply SHALL use shift-add on the absolute values of 32-bit operands, forming a 64-bit unsigned product. The sign is applied in DONE:
- MULH: sign = a[31]^b[31];
- MULHSU: sign = a[31];
- MULHU: unsigned.
REQ-020 Multiply result SHALL be product[31:0] for MUL and product[63:32] otherwise.
REQ-021 Divide SHALL use a restoring algorithm on absolute values. Signs:
- quotient sign = a[31]^b[31] for DIV;
- remainder sign = a[31] for REM.
REQ-022 Divide by zero SHALL yield quotient 32'hFFFF_FFFF and remainder = op_a, in all signed and unsigned variants.
REQ-023 Signed overflow (op_a = 32'h8000_0000, op_b = 32'hFFFF_FFFF, DIV/REM) SHALL yield quotient 32'h8000_0000 and remainder 0.
REQ-024 The special cases in REQ-022/023 SHALL still take the full 33-cycle latency.
REQ-025 start asserted while busy SHALL be ignored; the requester holds start under stall.
REQ-026 kill SHALL have priority over start in the same cycle. An aborted op SHALL never pulse done, and result SHALL be unchanged.
REQ-027 result and rd_out SHALL hold their last values until the next done.

Reset
REQ-028 On rst the block SHALL set: state IDLE, count 0, busy 0, done 0, result 32'h0, rd_out 5'h0, and clear all internal accumulators.
REQ-029 rst asserted mid-operation SHALL abort the op without a done pulse.
REQ-030 rst SHALL have priority over kill and start.

Configuration
REQ-031 Macro MULDIV_DIVIDE_EN SHALL control the divide datapath:
- defined: divide datapath and funct3_in[2]=1 ops are supported as above;
- undefined: no divider hardware. funct3_in[2]=1 ops go IDLE->DONE directly (done at N+1) with result 32'h0. Multiply behaviour is unchanged.

Structure
REQ-032 Package muldiv_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- localparams for the eight funct3 codes;
- XLEN = 32 and ITER = 32.
REQ-033 A single combinational sub-module, muldiv_sign_fix, SHALL perform the REQ-019..023 result correction from magnitude result, latched signs and special-case flags.

Verification
REQ-034 MUL: op_a 7, op_b -3 (32'hFFFF_FFFD) -> done at N+33, result 32'hFFFF_FFEB, stall high cycles N..N+32.
REQ-035 MULHU: op_a 32'hFFFF_FFFF, op_b 32'hFFFF_FFFF -> result 32'hFFFF_FFFE.
REQ-036 DIV: op_a -7, op_b 2 -> result 32'hFFFF_FFFD; REM with the same operands -> 32'hFFFF_FFFF.
REQ-037 DIVU with op_b 0, op_a 5 -> 32'hFFFF_FFFF; REM with op_a 32'h8000_0000, op_b -1 -> 0.
REQ-038 Abort: start MUL, assert kill at N+10 -> IDLE at N+11, no done, result unchanged. Repeat with rst in place of kill.
REQ-039 Back-to-back: a second start held during busy is accepted in the cycle after done; with MULDIV_DIVIDE_EN undefined, DIV -> done at N+1, result 0.
